// File: rtl/simd_result_wb_arbiter.sv
// Purpose: collects SIMD unit results in per-source FIFOs and serialises them onto one regfile write port.
// Latency: 2 cycles from src_v to wb_v when the arbiter is idle (an empty FIFO never bypasses).
// Backpressure: wb_ready low holds the output register; the unit pipelines cannot stall, so stall[i] throttles issue and overflow[i] records drops.
module simd_result_wb_arbiter #(
    parameter int VLEN         = 256,
    parameter int NSRC         = 4,
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 6,
    localparam int SW          = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NSRC-1:0]      i_src_v,
    input  logic [3*NSRC-1:0]    i_src_vrd,
    input  logic [VLEN*NSRC-1:0] i_src_vdata,
    output logic [NSRC-1:0]      o_stall,
    output logic [NSRC-1:0]      o_overflow,
    output logic                 o_wb_v,
    input  logic                 i_wb_ready,
    output logic [2:0]           o_wb_vrd,
    output logic [VLEN-1:0]      o_wb_vdata,
    output logic [SW-1:0]        o_wb_src,
    output logic                 o_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Per-source FIFO storage and bookkeeping
    logic [2:0]      r_mem_vrd   [NSRC][DEPTH];
    logic [VLEN-1:0] r_mem_vdata [NSRC][DEPTH];
    logic [AW-1:0]   r_wr_ptr    [NSRC];
    logic [AW-1:0]   r_rd_ptr    [NSRC];
    logic [CW-1:0]   r_count     [NSRC];
    logic [NSRC-1:0] r_overflow;

    // Output register and round-robin pointer
    logic            r_wb_v;
    logic [2:0]      r_wb_vrd;
    logic [VLEN-1:0] r_wb_vdata;
    logic [SW-1:0]   r_wb_src;
    logic [SW-1:0]   r_rr_last;

    logic            w_load;
    logic            w_found;
    logic [SW-1:0]   w_gidx;
    logic [NSRC-1:0] w_pop;
    logic [NSRC-1:0] w_push;
    logic [NSRC-1:0] w_drop;

    // Source index k steps after the last winner, wrapping modulo NSRC
    function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] last, input int k);
        return SW'((int'(last) + k) % NSRC);
    endfunction

    assign w_load = !r_wb_v || i_wb_ready;

    // Round-robin search: first non-empty FIFO after the previous winner
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NSRC; k++) begin
            if (!w_found && (r_count[rr_next(r_rr_last, k)] != '0)) begin
                w_found = 1'b1;
                w_gidx  = rr_next(r_rr_last, k);
            end
        end
    end

    // Pop only the granted FIFO; a full FIFO still accepts a push in the cycle it is popped
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_pop[i]  = w_load && w_found && (w_gidx == SW'(i));
            w_push[i] = i_src_v[i] && ((r_count[i] != CW'(DEPTH)) || w_pop[i]);
            w_drop[i] = i_src_v[i] && (r_count[i] == CW'(DEPTH)) && !w_pop[i];
        end
    end

    // FIFO payload write; contents need no reset because counts gate every read
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (w_push[i]) begin
                r_mem_vrd[i][r_wr_ptr[i]]   <= i_src_vrd[3*i +: 3];
                r_mem_vdata[i][r_wr_ptr[i]] <= i_src_vdata[VLEN*i +: VLEN];
            end
        end
    end

    // Pointers, occupancy and sticky drop flags
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NSRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                if (w_push[i] && !w_pop[i])      r_count[i] <= r_count[i] + 1'b1;
                else if (!w_push[i] && w_pop[i]) r_count[i] <= r_count[i] - 1'b1;
                if (w_drop[i]) r_overflow[i] <= 1'b1;
            end
        end
    end

    // Writeback register: load the granted head, or go invalid while holding the data
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wb_v     <= 1'b0;
            r_wb_vrd   <= '0;
            r_wb_vdata <= '0;
            r_wb_src   <= '0;
            r_rr_last  <= SW'(NSRC - 1);
        end else if (w_load) begin
            if (w_found) begin
                r_wb_v     <= 1'b1;
                r_wb_vrd   <= r_mem_vrd[w_gidx][r_rd_ptr[w_gidx]];
                r_wb_vdata <= r_mem_vdata[w_gidx][r_rd_ptr[w_gidx]];
                r_wb_src   <= w_gidx;
                r_rr_last  <= w_gidx;
            end else begin
                r_wb_v <= 1'b0;
            end
        end
    end

    // Issue throttle from registered occupancy, and the global idle indication
    always_comb begin
        logic all_empty;
        all_empty = 1'b1;
        o_stall   = '0;
        for (int i = 0; i < NSRC; i++) begin
            o_stall[i] = (DEPTH - int'(r_count[i])) <= STALL_MARGIN;
            if (r_count[i] != '0) all_empty = 1'b0;
        end
        o_idle = all_empty && !r_wb_v;
    end

    assign o_overflow = r_overflow;
    assign o_wb_v     = r_wb_v;
    assign o_wb_vrd   = r_wb_vrd;
    assign o_wb_vdata = r_wb_vdata;
    assign o_wb_src   = r_wb_src;

endmodule

// File: tb/tb_simd_result_wb_arbiter.sv
// Scoreboarded bench for simd_result_wb_arbiter: a queue-based reference model predicts
// every writeback beat and the per-cycle status outputs; a negedge monitor checks beats.
module tb_simd_result_wb_arbiter;

    localparam int VLEN   = 256;
    localparam int NSRC   = 4;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 6;

    typedef struct packed {
        logic [2:0]      vrd;
        logic [VLEN-1:0] data;
        logic [1:0]      src;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic [NSRC-1:0]      i_src_v;
    logic [3*NSRC-1:0]    i_src_vrd;
    logic [VLEN*NSRC-1:0] i_src_vdata;
    logic [NSRC-1:0]      o_stall;
    logic [NSRC-1:0]      o_overflow;
    logic                 o_wb_v;
    logic                 i_wb_ready;
    logic [2:0]           o_wb_vrd;
    logic [VLEN-1:0]      o_wb_vdata;
    logic [1:0]           o_wb_src;
    logic                 o_idle;

    simd_result_wb_arbiter #(
        .VLEN(VLEN), .NSRC(NSRC), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_src_v(i_src_v), .i_src_vrd(i_src_vrd), .i_src_vdata(i_src_vdata),
        .o_stall(o_stall), .o_overflow(o_overflow),
        .o_wb_v(o_wb_v), .i_wb_ready(i_wb_ready),
        .o_wb_vrd(o_wb_vrd), .o_wb_vdata(o_wb_vdata), .o_wb_src(o_wb_src),
        .o_idle(o_idle)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    beat_t           mq [NSRC][$];
    beat_t           exp_q [$];
    beat_t           m_cur;
    logic            m_wb_v;
    int              m_rr;
    logic [NSRC-1:0] m_ovf;

    logic [2:0]      d_vrd  [NSRC];
    logic [VLEN-1:0] d_data [NSRC];

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rnd_vec();
        logic [VLEN-1:0] v;
        for (int l = 0; l < VLEN/32; l++) v[32*l +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_src(input int i, input logic [2:0] vrd, input logic [VLEN-1:0] data);
        d_vrd[i]  = vrd;
        d_data[i] = data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) mq[i].delete();
        exp_q.delete();
        m_cur  = '0;
        m_wb_v = 1'b0;
        m_rr   = NSRC - 1;
        m_ovf  = '0;
    endtask

    // What the coming clock edge does, from the arbitration and FIFO rules
    task automatic model_step(input logic [NSRC-1:0] v, input logic rdy);
        int g;
        g = -1;
        if (!m_wb_v || rdy) begin
            for (int k = 1; k <= NSRC; k++) begin
                int j;
                j = (m_rr + k) % NSRC;
                if (g < 0 && mq[j].size() > 0) g = j;
            end
            if (g >= 0) begin
                m_cur  = mq[g].pop_front();
                exp_q.push_back(m_cur);
                m_wb_v = 1'b1;
                m_rr   = g;
            end else begin
                m_wb_v = 1'b0;
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) begin
                if (mq[i].size() < DEPTH) begin
                    beat_t b;
                    b.vrd  = d_vrd[i];
                    b.data = d_data[i];
                    b.src  = 2'(i);
                    mq[i].push_back(b);
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic status_check();
        logic [NSRC-1:0] exp_stall;
        logic            all_empty;
        all_empty = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            exp_stall[i] = (DEPTH - mq[i].size()) <= MARGIN;
            if (mq[i].size() != 0) all_empty = 1'b0;
        end
        check("wb_v", o_wb_v, m_wb_v);
        check("wb_vrd", o_wb_vrd, m_cur.vrd);
        check("wb_vdata", o_wb_vdata, m_cur.data);
        check("wb_src", o_wb_src, m_cur.src);
        check("stall", o_stall, exp_stall);
        check("overflow", o_overflow, m_ovf);
        check("idle", o_idle, all_empty && !m_wb_v);
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then compare status
    task automatic cycle(input logic [NSRC-1:0] v, input logic rdy);
        i_src_v    = v;
        i_wb_ready = rdy;
        for (int i = 0; i < NSRC; i++) begin
            i_src_vrd[3*i +: 3]         = d_vrd[i];
            i_src_vdata[VLEN*i +: VLEN] = d_data[i];
        end
        model_step(v, rdy);
        @(posedge clk);
        #1;
        status_check();
    endtask

    // Monitor: each accepted writeback must be the oldest predicted beat
    always @(negedge clk) begin
        if (!i_reset && o_wb_v && i_wb_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL wb_beat: got beat src=%0d vrd=%0d, expected no beat", o_wb_src, o_wb_vrd);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_src", o_wb_src, e.src);
                check("beat_vrd", o_wb_vrd, e.vrd);
                check("beat_vdata", o_wb_vdata, e.data);
            end
        end
    end

    initial begin
        logic [VLEN-1:0] lanes;
        logic            saw_stall;
        logic [NSRC-1:0] v;

        i_reset     = 1'b1;
        i_src_v     = '0;
        i_src_vrd   = '0;
        i_src_vdata = '0;
        i_wb_ready  = 1'b0;
        for (int i = 0; i < NSRC; i++) set_src(i, 3'd0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        status_check();
        i_reset = 1'b0;

        // Single result from source 2
        for (int l = 0; l < VLEN/32; l++) lanes[32*l +: 32] = 32'(l + 1);
        set_src(2, 3'd5, lanes);
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Two simultaneous bursts from all sources
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NSRC; i++) set_src(i, 3'(i), rnd_vec());
            cycle(4'b1111, 1'b1);
            repeat (6) cycle(4'b0000, 1'b1);
        end

        // Backpressure with entries pending, then release
        for (int i = 0; i < NSRC; i++) set_src(i, 3'(i + 4), rnd_vec());
        cycle(4'b1111, 1'b0);
        repeat (11) cycle(4'b0000, 1'b0);
        repeat (6) cycle(4'b0000, 1'b1);

        // Fairness between two continuously producing sources that honour stall
        saw_stall = 1'b0;
        repeat (40) begin
            v = {2'b00, ~o_stall[1:0]};
            set_src(0, 3'($urandom), rnd_vec());
            set_src(1, 3'($urandom), rnd_vec());
            cycle(v, 1'b1);
            if (o_stall[1:0] != 2'b00) saw_stall = 1'b1;
        end
        repeat (8) cycle(4'b0000, 1'b1);
        check("stall_seen", saw_stall, 1'b1);

        // Overflow on source 3: the output register absorbs entry 1, so entry 10 is the drop
        for (int k = 1; k <= 10; k++) begin
            lanes = '0;
            lanes[31:0] = 32'(k);
            set_src(3, 3'(k), lanes);
            cycle(4'b1000, 1'b0);
        end
        check("ovf3_set", o_overflow[3], 1'b1);
        check("stall3_set", o_stall[3], 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        check("ovf3_sticky", o_overflow[3], 1'b1);

        // Randomised traffic and backpressure
        repeat (400) begin
            for (int i = 0; i < NSRC; i++) begin
                v[i] = ($urandom_range(0, 2) == 0);
                set_src(i, 3'($urandom), rnd_vec());
            end
            cycle(v, ($urandom_range(0, 3) != 0));
        end
        repeat (40) cycle(4'b0000, 1'b1);

        // Asynchronous reset with three results in flight
        for (int i = 0; i < 3; i++) set_src(i, 3'(i + 1), rnd_vec());
        cycle(4'b0111, 1'b0);
        cycle(4'b0000, 1'b0);
        check("pre_reset_wb_v", o_wb_v, 1'b1);
        i_src_v = '0;
        i_reset = 1'b1;
        #1;
        check("async_rst_wb_v", o_wb_v, 1'b0);
        check("async_rst_idle", o_idle, 1'b1);
        model_reset();
        @(posedge clk);
        #2;
        i_reset = 1'b0;
        repeat (10) cycle(4'b0000, 1'b1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
